// File: rtl/root_channel_array_if.sv
// Bus bundle for root_channel_array: job input, result output, status and
// a per-channel state view for observation.
//
// Handshake: a transfer occurs on a rising clk edge where valid && ready are
// both high. ready depends only on the receiver's current state. valid and
// payload must be held stable by the sender until that transfer occurs.
interface root_channel_array_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [$clog2(NUM_CH)-1:0]     out_ch;
  logic [$clog2(NUM_CH+1)-1:0]   occupancy;
  logic [CNT_W-1:0]              done_count;
  // Channel i state lives in bits [2*i +: 2]: 0=IDLE, 1=BUSY, 2=DONE.
  logic [2*NUM_CH-1:0]           ch_state;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, occupancy, done_count, ch_state
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, occupancy, done_count, ch_state
  );
endinterface

// File: rtl/root_channel_array.sv
// Array of NUM_CH fixed-latency worker channels. Jobs are dispatched
// round-robin to idle channels; finished results are returned round-robin
// on a single backpressured output port.
module root_channel_array #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int LAT    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  root_channel_array_if.slave    bus
);

  localparam int PTR_W  = $clog2(NUM_CH);
  localparam int OCC_W  = $clog2(NUM_CH + 1);
  localparam int LCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  ch_state_t           state_q [NUM_CH];
  ch_state_t           state_d [NUM_CH];
  logic [LCNT_W-1:0]   cnt_q   [NUM_CH];
  logic [DATA_W-1:0]   res_q   [NUM_CH];

  logic [NUM_CH-1:0]   idle_vec;
  logic [NUM_CH-1:0]   done_vec;
  logic [PTR_W-1:0]    disp_ptr_q;
  logic [PTR_W-1:0]    out_ptr_q;
  logic [PTR_W-1:0]    disp_tgt;
  logic [PTR_W-1:0]    out_sel;
  logic                disp_hit;
  logic                sel_hit;
  logic                in_ready_w;
  logic                out_valid_w;
  logic                disp_fire;
  logic                out_fire;
  logic [CNT_W-1:0]    done_count_q;
  logic [OCC_W-1:0]    occ;
  logic [2*NUM_CH-1:0] ch_state_w;

  // Advance a channel pointer by one, wrapping at NUM_CH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_CH - 1)) next_ptr = '0;
    else                         next_ptr = p + PTR_W'(1);
  endfunction

  // Per-channel status flags and the debug state view.
  always_comb begin
    idle_vec   = '0;
    done_vec   = '0;
    ch_state_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idle_vec[i]          = (state_q[i] == ST_IDLE);
      done_vec[i]          = (state_q[i] == ST_DONE);
      ch_state_w[2*i +: 2] = state_q[i];
    end
  end

  // Dispatch target: first IDLE channel scanning cyclically from disp_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    disp_hit = 1'b0;
    disp_tgt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(disp_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!disp_hit && idle_vec[idx]) begin
        disp_hit = 1'b1;
        disp_tgt = PTR_W'(idx);
      end
    end
  end

  // Output select: first DONE channel scanning cyclically from out_ptr.
  always_comb begin
    int idx;
    idx     = 0;
    sel_hit = 1'b0;
    out_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(out_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!sel_hit && done_vec[idx]) begin
        sel_hit = 1'b1;
        out_sel = PTR_W'(idx);
      end
    end
  end

  // Occupancy is the count of channels that are not IDLE.
  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!idle_vec[i]) occ = occ + OCC_W'(1);
    end
  end

  // Flush suppresses both handshakes in the cycle it is asserted.
  assign in_ready_w  = |idle_vec;
  assign out_valid_w = sel_hit;
  assign disp_fire   = bus.in_valid && in_ready_w && !bus.flush;
  assign out_fire    = out_valid_w && bus.out_ready && !bus.flush;

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_data   = out_valid_w ? res_q[out_sel] : '0;
  assign bus.out_ch     = out_valid_w ? out_sel : '0;
  assign bus.occupancy  = occ;
  assign bus.done_count = done_count_q;
  assign bus.ch_state   = ch_state_w;

  // Channel FSM next state. A channel released by the output handshake only
  // reads IDLE next cycle, so it cannot be re-dispatched in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      if (bus.flush) begin
        state_d[i] = ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: if (disp_fire && disp_tgt == PTR_W'(i)) state_d[i] = ST_BUSY;
          ST_BUSY: if (cnt_q[i] == '0)                     state_d[i] = ST_DONE;
          ST_DONE: if (out_fire && out_sel == PTR_W'(i))   state_d[i] = ST_IDLE;
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  // Channel datapath: load result and latency count on dispatch, count down while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (disp_fire && disp_tgt == PTR_W'(i)) begin
          cnt_q[i] <= LCNT_W'(LAT - 1);
          res_q[i] <= bus.in_data + DATA_W'(i);
        end else if (state_q[i] == ST_BUSY && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - LCNT_W'(1);
        end
      end
    end
  end

  // Round-robin pointers move past the channel just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr_q <= '0;
      out_ptr_q  <= '0;
    end else if (bus.flush) begin
      disp_ptr_q <= '0;
      out_ptr_q  <= '0;
    end else begin
      if (disp_fire) disp_ptr_q <= next_ptr(disp_tgt);
      if (out_fire)  out_ptr_q  <= next_ptr(out_sel);
    end
  end

  // Completed-job counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           done_count_q <= '0;
    else if (out_fire) done_count_q <= done_count_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_root_channel_array.sv
// Directed bench for root_channel_array (NUM_CH=5, DATA_W=8, LAT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_root_channel_array;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int LAT    = 4;
  localparam int CNT_W  = 16;
  localparam int W      = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  root_channel_array_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  root_channel_array #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  // Drain exp_q against accepted outputs; entries are {ch, data}.
  task automatic collect(input string tag);
    logic [W-1:0] e;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        check(tag, {bus.out_ch, bus.out_data}, e);
      end
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  logic [DATA_W-1:0] t4_vals [5];
  int n;

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_done_cnt", bus.done_count, 0);
    check("rst_state", bus.ch_state, 0);
    rst = 1'b0;

    // T1: single job, latency and result
    bus.out_ready = 1'b1;
    send(8'h10);
    bus.in_valid = 1'b0;
    check("t1_occ", bus.occupancy, 1);
    check("t1_state", bus.ch_state, 10'h001);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", n, LAT);
    check("t1_data", bus.out_data, 8'h10);
    check("t1_ch", bus.out_ch, 0);
    @(negedge clk);
    check("t1_valid_drop", bus.out_valid, 0);
    check("t1_done_cnt", bus.done_count, 1);
    check("t1_occ_end", bus.occupancy, 0);

    // T2: fill all channels with no consumer
    do_reset();
    bus.out_ready = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      check("t2_in_ready", bus.in_ready, 1);
      check("t2_occ", bus.occupancy, j);
      send(8'(j + 1));
    end
    bus.in_data = 8'h06;
    check("t2_full_ready", bus.in_ready, 0);
    check("t2_full_occ", bus.occupancy, 5);
    check("t2_first_done", bus.out_valid, 1);
    check("t2_first_ch", bus.out_ch, 0);
    check("t2_first_data", bus.out_data, 8'h01);
    repeat (4) @(negedge clk);
    check("t2_all_done", bus.ch_state, 10'h2AA);
    check("t2_held_ready", bus.in_ready, 0);
    check("t2_held_occ", bus.occupancy, 5);
    bus.in_valid = 1'b0;

    // T3: round-robin drain with continuous ready
    bus.out_ready = 1'b1;
    exp_q.push_back({3'd0, 8'h01});
    exp_q.push_back({3'd1, 8'h03});
    exp_q.push_back({3'd2, 8'h05});
    exp_q.push_back({3'd3, 8'h07});
    exp_q.push_back({3'd4, 8'h09});
    collect("t3_out");
    check("t3_valid_end", bus.out_valid, 0);
    check("t3_done_cnt", bus.done_count, 5);
    check("t3_occ_end", bus.occupancy, 0);

    // T4: dispatch pointer wrap and result wraparound
    t4_vals[0] = 8'h20;
    t4_vals[1] = 8'h30;
    t4_vals[2] = 8'h00;
    t4_vals[3] = 8'h00;
    t4_vals[4] = 8'hFF;
    for (int j = 0; j < NUM_CH; j++) begin
      send(t4_vals[j]);
      if (j == 1) check("t4_two_busy", bus.ch_state, 10'h005);
    end
    bus.in_valid = 1'b0;
    exp_q.push_back({3'd0, 8'h20});
    exp_q.push_back({3'd1, 8'h31});
    exp_q.push_back({3'd2, 8'h02});
    exp_q.push_back({3'd3, 8'h03});
    exp_q.push_back({3'd4, 8'h03});
    collect("t4_out");
    check("t4_done_cnt", bus.done_count, 10);
    check("t4_occ_end", bus.occupancy, 0);

    // T5: output handshake and pending dispatch in the same cycle
    bus.out_ready = 1'b0;
    for (int j = 0; j < NUM_CH; j++) send(8'(j + 1));
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_all_done", bus.ch_state, 10'h2AA);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h40;
    bus.out_ready = 1'b1;
    check("t5_ready_full", bus.in_ready, 0);
    check("t5_sel_ch", bus.out_ch, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t5_occ_after_out", bus.occupancy, 4);
    check("t5_ready_freed", bus.in_ready, 1);
    check("t5_no_dispatch", bus.ch_state, 10'h2A8);
    check("t5_done_cnt", bus.done_count, 11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_occ_redisp", bus.occupancy, 5);
    check("t5_state_redisp", bus.ch_state, 10'h2A9);
    check("t5_next_ch", bus.out_ch, 1);
    check("t5_next_data", bus.out_data, 8'h03);

    // T6: flush beats both handshakes, done_count held
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_flush_occ", bus.occupancy, 0);
    check("t6_flush_ready", bus.in_ready, 1);
    check("t6_flush_valid", bus.out_valid, 0);
    check("t6_flush_data", bus.out_data, 0);
    check("t6_flush_cnt", bus.done_count, 11);
    send(8'hA0);
    send(8'hA1);
    send(8'hA2);
    bus.in_valid = 1'b0;
    check("t6_busy3_state", bus.ch_state, 10'h015);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_midjob_occ", bus.occupancy, 0);
    check("t6_midjob_ready", bus.in_ready, 1);
    check("t6_midjob_cnt", bus.done_count, 11);
    repeat (6) @(negedge clk);
    check("t6_discarded", bus.out_valid, 0);

    // Async reset mid-job drops outputs before the next clock edge
    send(8'hB0);
    send(8'hB1);
    send(8'hB2);
    bus.in_valid = 1'b0;
    check("t6_pre_rst_occ", bus.occupancy, 3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_occ", bus.occupancy, 0);
    check("t6_rst_ready", bus.in_ready, 1);
    check("t6_rst_cnt", bus.done_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_rst_discarded", bus.out_valid, 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
